// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: FSM encoding, client count
// and the rotating-priority search used to pick the next owner.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam int N_CLIENTS = 4;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } winner_t;

    // Scanning from the far end back towards start leaves the first hit in
    // search order as the final value.
    function automatic winner_t next_winner(input logic [N_CLIENTS-1:0] req,
                                            input logic [1:0]           start);
        winner_t    w;
        logic [1:0] cand;
        w = '0;
        for (int k = N_CLIENTS - 1; k >= 0; k--) begin
            cand = start + 2'(k);
            if (req[cand]) begin
                w.found = 1'b1;
                w.idx   = cand;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/dec2to4.sv
// Plain 2-to-4 one-hot decoder, shared across the lab designs.
module dec2to4 (
    input  logic [1:0] D,
    output logic [3:0] Y
);

    always_comb begin
        Y    = 4'b0000;
        Y[D] = 1'b1;
    end

endmodule

// File: rtl/rr_arb4.sv
// Four-client round-robin arbiter with a bounded hold time; the grant is
// formed from registered state only, so req never reaches gnt combinationally.
module rr_arb4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = $clog2(MAX_HOLD)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CLIENTS-1:0] req,
    output logic [N_CLIENTS-1:0] gnt,
    output logic [1:0]           gnt_id,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD - 1);

    state_t               state, state_n;
    logic [1:0]           owner, owner_n;
    logic [1:0]           ptr, ptr_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [N_CLIENTS-1:0] owner_dec;
    logic [N_CLIENTS-1:0] others;
    winner_t              pick_ptr, pick_next;
    logic                 take;
    logic [1:0]           take_idx;

    dec2to4 u_dec (
        .D (owner),
        .Y (owner_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= 2'd0;
            ptr   <= 2'd0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
        end
    end

    // Handovers search from owner+1 among the other requesters; a fresh grant
    // from IDLE searches from the rotating pointer.
    always_comb begin
        state_n   = state;
        owner_n   = owner;
        ptr_n     = ptr;
        cnt_n     = cnt;
        take      = 1'b0;
        take_idx  = 2'd0;
        others    = req & ~owner_dec;
        pick_ptr  = next_winner(req, ptr);
        pick_next = next_winner(others, owner + 2'd1);

        case (state)
            IDLE: begin
                if (pick_ptr.found) begin
                    state_n  = OWN;
                    take     = 1'b1;
                    take_idx = pick_ptr.idx;
                end
            end
            OWN: begin
                if (!req[owner]) begin
                    if (pick_next.found) begin
                        take     = 1'b1;
                        take_idx = pick_next.idx;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end else if (cnt == HOLD_LIMIT) begin
                    if (pick_next.found) begin
                        take     = 1'b1;
                        take_idx = pick_next.idx;
                    end else begin
                        cnt_n = '0;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (take) begin
            owner_n = take_idx;
            ptr_n   = take_idx + 2'd1;
            cnt_n   = '0;
        end
    end

    assign busy   = (state == OWN);
    assign gnt_id = owner;
    assign gnt    = owner_dec & {N_CLIENTS{busy}};

endmodule

// File: tb/tb_rr_arb4.sv
// Directed and randomised checks of the round-robin arbiter with MAX_HOLD=8.
module tb_rr_arb4;

    localparam int MAX_HOLD = 8;
    localparam int WAIT_MAX = 3 * MAX_HOLD;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;

    int vectors;
    int miscompares;

    rr_arb4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at the falling edge; outputs are sampled at the next
    // falling edge, i.e. one rising edge after the request was applied.
    task automatic applyStimulus(input logic [3:0] r);
        req = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expectGrant(input string tag, input logic [3:0] g);
        logic [1:0] id;
        id = 2'd0;
        for (int i = 0; i < 4; i++)
            if (g[i]) id = 2'(i);
        checkOutput({tag, ".gnt"}, 32'(gnt), 32'(g));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(g != 4'b0000));
        if (g != 4'b0000)
            checkOutput({tag, ".id"}, 32'(gnt_id), 32'(id));
    endtask

    initial begin
        logic [3:0] r;
        logic [3:0] e;
        int         waits [4];
        int         worst;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        req         = 4'b0000;
        @(negedge clk);

        // Held in reset with everyone requesting
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1111);
            expectGrant("reset", 4'b0000);
            checkOutput("reset.id", 32'(gnt_id), 32'd0);
        end

        // Rotation: each client holds exactly MAX_HOLD cycles, no gaps
        rst = 1'b0;
        for (int k = 0; k < 5 * MAX_HOLD; k++) begin
            applyStimulus(4'b1111);
            e = 4'b0001 << ((k / MAX_HOLD) % 4);
            expectGrant("rotate", e);
        end

        // Release and back-to-back handover from client 2 to client 3
        applyStimulus(4'b0000);
        expectGrant("drain", 4'b0000);
        applyStimulus(4'b0100);
        expectGrant("own2", 4'b0100);
        applyStimulus(4'b1010);
        expectGrant("handover", 4'b1000);
        applyStimulus(4'b0000);
        expectGrant("release", 4'b0000);

        // Lone holder keeps the grant across counter wraps
        for (int k = 0; k < 30; k++) begin
            applyStimulus(4'b0010);
            expectGrant("lone", 4'b0010);
        end
        applyStimulus(4'b0000);
        expectGrant("lone_drop", 4'b0000);

        // Owner 3 releases exactly on its limit cycle; search wraps to 0
        for (int k = 0; k < MAX_HOLD; k++) begin
            applyStimulus(4'b1000);
            expectGrant("own3", 4'b1000);
        end
        applyStimulus(4'b0101);
        expectGrant("limit_rel", 4'b0001);
        for (int k = 1; k < MAX_HOLD; k++) begin
            applyStimulus(4'b0101);
            expectGrant("fresh_cnt", 4'b0001);
        end
        applyStimulus(4'b0101);
        expectGrant("ptr_wrap", 4'b0100);

        // Reset while client 2 owns
        rst = 1'b1;
        applyStimulus(4'b1111);
        expectGrant("mid_reset", 4'b0000);
        checkOutput("mid_reset.id", 32'(gnt_id), 32'd0);
        rst = 1'b0;

        // Random slowly-changing request stream with invariant checks
        for (int i = 0; i < 4; i++) waits[i] = 0;
        r = 4'b0000;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
            applyStimulus(r);
            checkOutput("rand.onehot", 32'($countones(gnt) <= 1), 32'd1);
            checkOutput("rand.busy", 32'(busy), 32'(|gnt));
            checkOutput("rand.unreq", 32'(gnt & ~r), 32'd0);
            checkOutput("rand.idle", 32'(busy), 32'(r != 4'b0000 || gnt != 4'b0000));
            worst = 0;
            for (int i = 0; i < 4; i++) begin
                if (r[i] && !gnt[i]) waits[i]++;
                else waits[i] = 0;
                if (waits[i] > worst) worst = waits[i];
            end
            checkOutput("rand.starve", 32'(worst <= WAIT_MAX), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_arb4.md
# rr_arb4

Four-requester round-robin arbiter with a bounded hold time. It shares one resource among four clients and drives a one-hot grant vector through the team's 2-to-4 decoder. It sits in front of any single-port resource, such as a shared bus, register file port or ALU, that several datapath units must access. Fairness is guaranteed by a rotating priority pointer and a per-grant hold limit.

## Interface
- MAX_HOLD, default 8: maximum consecutive cycles one client may own the grant while others are waiting; legal range 2..256.
- CNT_W, default $clog2(MAX_HOLD): width of the hold counter.

- clk: input, 1 bit. Single clock; all state updates on the rising edge.
- rst: input, 1 bit. Synchronous, active-high reset.
- req: input, 4 bits. req[i]=1 means client i requests the resource. Level-sensitive.
- gnt: output, 4 bits. One-hot grant, registered; 4'b0000 when idle.
- gnt_id: output, 2 bits. Encoded index of the current owner; valid only when busy=1.
- busy: output, 1 bit. 1 while any grant is active.

## Operation
- State machine:
  - IDLE: gnt=0, busy=0.
  - OWN: exactly one gnt bit set, busy=1.
- Priority pointer ptr[1:0]:
  - Search order is ptr, ptr+1, ptr+2, ptr+3, modulo 4 (wraps 3→0).
  - The winner is the first index i in that order with req[i]=1.
- IDLE → OWN: when any req bit is 1, load owner with the winner and clear the hold counter to 0.
- OWN, owner drops req:
  - If any other req is 1, switch to the new winner, searching from owner+1. The handover is back-to-back, with no idle cycle.
  - Otherwise go to IDLE.
- OWN, owner keeps req:
  - Counter increments each cycle.
  - When the counter reaches MAX_HOLD-1 and another client is requesting, force a handover to the winner searched from owner+1.
  - When the counter reaches MAX_HOLD-1 and no other client is requesting, the owner keeps the grant and the counter restarts at 0.
- On every new grant, set ptr to winner+1 (mod 4), so the last owner gets lowest priority next time.
- Outputs:
  - gnt_id equals the owner register.
  - gnt = decode(owner) gated by busy; one-hot is guaranteed by construction.
- The arbiter never grants a client whose req is 0 in the cycle the grant decision is made.

## Timing
- Reset (rst=1 at an edge): state=IDLE, gnt=4'b0000, gnt_id=2'd0, busy=0, ptr=2'd0, counter=0.
  - Reset mid-grant drops gnt on the next edge, whatever req is.
- Request-to-grant latency is 1 cycle: req sampled at edge n appears as gnt after edge n.
- Release latency is 1 cycle: owner req low at edge n means gnt is removed or switched after edge n.
- Maximum owned cycles while others wait: MAX_HOLD.
- Worst-case wait for a continuously requesting client: 3·MAX_HOLD cycles.
- Simultaneous events:
  - All four requesting at once: the pointer decides the winner.
  - Owner releases on the same cycle the counter hits the limit: treat it as a release. The search starts from owner+1 and the counter is cleared.
- Outputs come directly from registers; there is no combinational path from req to gnt.

## Structure
- Shared package arb_pkg holds:
  - The state encoding (IDLE=1'b0, OWN=1'b1).
  - The N_CLIENTS=4 constant.
  - A function next_winner(req, start), returning a found flag and a 2-bit index.
- One sub-module: the existing dec2to4. It is instantiated once, with D=owner, and Y is ANDed with busy to form gnt.
- The counter, pointer and FSM live in rr_arb4 itself.

## Test plan
- Reset behaviour: req=4'b1111 while rst=1 for 3 cycles → gnt=0, busy=0. After releasing rst → gnt=4'b0001 one cycle later (ptr=0).
- Rotation: req=4'b1111 held, MAX_HOLD=8 → grant sequence 0001, 0010, 0100, 1000, 0001, each held exactly 8 cycles, with no idle gaps.
- Release and handover: client 2 owns; req=4'b1010 and req[2] falls → next cycle gnt=4'b1000 (search from 3). A further release with no other requests → IDLE, gnt=0.
- Lone holder: only req[1]=1 for 30 cycles → gnt=4'b0010 for all 30 cycles, with the counter wrapping silently. req[1] drops → gnt=0 one cycle later.
- Wrap-around and simultaneous events:
  - Owner 3 is released on the limit cycle with req=4'b0101 → gnt=4'b0001, ptr wraps to 1.
  - Reset asserted mid-grant → gnt=0 on the next edge.
- Random req stream for 10k cycles, with continuous checks:
  - gnt is one-hot or zero.
  - A client is granted only while it requests.
  - No client waits more than 3·MAX_HOLD cycles.
  - busy equals |gnt.
